data_mem_ctrl: RTL

//  Parametrised single-clock data memory for the RV32 datapath; successor of the split-clock data RAM.

---
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-clock RV32 data memory. It accepts one load or store per
// valid/ready handshake and returns a registered response one cycle later.
// Loads are sign- or zero-extended. Illegal, out-of-range and misaligned accesses
// return RspErr.
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN. When it is defined, a misaligned
// H/HU/W access is split across two adjacent words, and the response takes 2 cycles.
module data_mem_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] Addr,
    input  logic [2:0]  MemOp,
    input  logic        WrEn,
    input  logic [31:0] DataIn,
    output logic        RspValid,
    output logic [31:0] DataOut,
    output logic        RspErr
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;
    state_t state_q, state_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          in_range, is_h, is_w, legal, misal, direct_ok, go_split, accept;
    logic [AW-1:0] widx, wr_addr, rd_addr;
    logic [1:0]    lane;
    logic [3:0]    mask4, be_lo, wr_be;
    logic [31:0]   wd_lo, wr_data, rd_word;
    logic          wr_en;
    logic [31:0]   dout_q;
    logic          err_q;

    // Extend a right-aligned load value according to funct3.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] op);
        case (op[1:0])
            2'b00:   return op[2] ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   return op[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign offset   = Addr - BASE_ADDR;
    assign in_range = offset < SPAN;
    assign widx     = offset[AW+1:2];
    assign lane     = offset[1:0];
    assign is_h     = (MemOp[1:0] == 2'b01);
    assign is_w     = (MemOp[1:0] == 2'b10);
    // Stores allow B/H/W only; loads also allow BU/HU.
    assign legal    = WrEn ? (!MemOp[2] && MemOp[1:0] != 2'b11)
                           : (MemOp[1:0] != 2'b11 && !(MemOp[2] && is_w));
    assign misal     = (is_h && lane[0]) || (is_w && lane != 2'b00);
    assign direct_ok = legal && in_range && !misal;
    assign mask4     = is_w ? 4'b1111 : (is_h ? 4'b0011 : 4'b0001);
    assign accept    = ReqValid && ReqReady && !Rst;
    assign rd_word   = mem[rd_addr];

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic [AW-1:0] nidx_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_data_q, lo_q, merged;
    logic [1:0]    lane_q;
    logic [2:0]    op_q;
    logic          wr_q;

    // A split is allowed only when the second word is also inside the memory.
    assign go_split = legal && in_range && misal && (widx != AW'(DEPTH_WORDS - 1));
    assign be8      = {4'b0000, mask4} << lane;
    assign wd64     = {32'b0, DataIn} << {lane, 3'b000};
    assign be_lo    = be8[3:0];
    assign wd_lo    = wd64[31:0];
    assign merged   = 32'({rd_word, lo_q} >> {lane_q, 3'b000});
    assign ReqReady = (state_q != SPLIT);

    // Capture the second-word half of a split access, and the first word it read.
    always_ff @(posedge Clk) begin
        if (accept && go_split) begin
            nidx_q    <= widx + AW'(1);
            hi_be_q   <= be8[7:4];
            hi_data_q <= wd64[63:32];
            lo_q      <= rd_word;
            lane_q    <= lane;
            op_q      <= MemOp;
            wr_q      <= WrEn;
        end
    end
`else
    assign go_split = 1'b0;
    assign be_lo    = mask4 << lane;
    assign wd_lo    = DataIn << {lane, 3'b000};
    assign ReqReady = 1'b1;
`endif

    // Select the single read/write port address: the accepted word, or the second split word.
    always_comb begin
        wr_en   = accept && direct_ok && WrEn;
        wr_addr = widx;
        rd_addr = widx;
        wr_be   = be_lo;
        wr_data = wd_lo;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (accept && go_split && WrEn) begin
            wr_en = 1'b1;
        end
        if (state_q == SPLIT) begin
            wr_en   = wr_q && !Rst;
            wr_addr = nidx_q;
            rd_addr = nidx_q;
            wr_be   = hi_be_q;
            wr_data = hi_data_q;
        end
`endif
    end

    // Byte-lane write. Memory contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accept goes to RESP (or to SPLIT first). RESP can chain directly into the next accept.
    always_comb begin
        state_d = IDLE;
        if (state_q == SPLIT) begin
            state_d = RESP;
        end else if (accept) begin
            state_d = go_split ? SPLIT : RESP;
        end
    end

    // Response data and error register. It holds its value between responses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dout_q <= 32'b0;
            err_q  <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        end else if (state_q == SPLIT) begin
            dout_q <= wr_q ? 32'b0 : load_ext(merged, op_q);
            err_q  <= 1'b0;
`endif
        end else if (accept && !go_split) begin
            if (!direct_ok) begin
                dout_q <= 32'b0;
                err_q  <= 1'b1;
            end else begin
                dout_q <= WrEn ? 32'b0 : load_ext(rd_word >> {lane, 3'b000}, MemOp);
                err_q  <= 1'b0;
            end
        end
    end

    assign RspValid = (state_q == RESP) && !Rst;
    assign DataOut  = dout_q;
    assign RspErr   = err_q;
endmodule
